// File: rtl/fetch_pc_unit.sv
// Fetch program-counter unit: next-PC selection (exception, redirect,
// stall, sequential) plus a small circular return-address stack that
// predicts JR $ra targets from JAL return addresses.
module fetch_pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             exc_valid,
   input  logic             ras_push,
   input  logic             ras_pop,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_overflow,
   output logic             misaligned
);

   localparam int               PTR_W    = $clog2(RAS_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);

   logic [WIDTH-1:0] pc_next;

   // Return-address stack state: storage, pointer to the current top
   // entry, number of valid entries, and the sticky discard flag.
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_ptr;
   logic [PTR_W-1:0] top_ptr_next;
   logic [CNT_W-1:0] ras_count;
   logic [CNT_W-1:0] ras_count_next;
   logic             ras_overflow_next;
   logic             ras_full;
   logic             ras_qual;
   logic             do_push;
   logic             do_pop;
   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;

   // Sequential address wraps modulo 2^WIDTH; misalignment is only reported.
   assign pc_plus4   = pc + PC_STEP;
   assign misaligned = |pc[1:0];

   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == CNT_FULL);
   assign ras_top   = ras_empty ? '0 : ras_mem[top_ptr];

   // A stalled fetch ignores RAS requests unless the PC is being redirected.
   assign ras_qual = !stall || exc_valid || redirect_valid;
   assign do_push  = ras_push && ras_qual;
   assign do_pop   = ras_pop && ras_qual;

   // Next-PC priority: exception, redirect, stall hold, sequential.
   always_comb begin
      pc_next = pc_plus4;
      if (exc_valid)
         pc_next = EXC_VECTOR;
      else if (redirect_valid)
         pc_next = redirect_target;
      else if (stall)
         pc_next = pc;
   end

   // RAS next-state: replace-top on push+pop, circular push, guarded pop.
   always_comb begin
      wr_en             = 1'b0;
      wr_ptr            = top_ptr;
      top_ptr_next      = top_ptr;
      ras_count_next    = ras_count;
      ras_overflow_next = ras_overflow;
      if (do_push && do_pop && !ras_empty) begin
         wr_en  = 1'b1;
         wr_ptr = top_ptr;
      end else if (do_push) begin
         // When full, top_ptr+1 is the oldest entry, so it is overwritten.
         wr_en        = 1'b1;
         wr_ptr       = top_ptr + PTR_ONE;
         top_ptr_next = top_ptr + PTR_ONE;
         if (ras_full)
            ras_overflow_next = 1'b1;
         else
            ras_count_next = ras_count + CNT_ONE;
      end else if (do_pop && !ras_empty) begin
         top_ptr_next   = top_ptr - PTR_ONE;
         ras_count_next = ras_count - CNT_ONE;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_VECTOR;
      else
         pc <= pc_next;
   end

   // RAS control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         top_ptr      <= '0;
         ras_count    <= '0;
         ras_overflow <= 1'b0;
      end else begin
         top_ptr      <= top_ptr_next;
         ras_count    <= ras_count_next;
         ras_overflow <= ras_overflow_next;
      end
   end

   // RAS storage is never cleared; a reset only drops the pending write.
   always_ff @(posedge clk) begin
      if (wr_en && !reset)
         ras_mem[wr_ptr] <= pc_plus4;
   end

endmodule
